cordic_share_arb: RTL and testbench
===================================

CORDIC_SHARE_ARB -- requirements
Module: cordic_share_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample width of all streams (SC16 I/Q).
REQ-002 SHALL have parameter TAG_AWIDTH, default 4, log2 of the maximum number of packets in flight through the shared resource.
REQ-003 SHALL have port clk  in  1  single clock for the whole block.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear  in  1  synchronous flush: arbiter to IDLE, tag FIFO emptied.
REQ-006 SHALL have ports s0_tdata/s0_tlast/s0_tvalid/s0_tready  in/in/in/out  WIDTH/1/1/1  requester 0 input stream.
REQ-007 SHALL have ports s1_tdata/s1_tlast/s1_tvalid/s1_tready  in/in/in/out  WIDTH/1/1/1  requester 1 input stream.
REQ-008 SHALL have ports r_tdata/r_tlast/r_tvalid/r_tready  out/out/out/in  WIDTH/1/1/1  stream to the shared resource (CORDIC/mult pipeline).
REQ-009 SHALL have ports rr_tdata/rr_tlast/rr_tvalid/rr_tready  in/in/in/out  WIDTH/1/1/1  result stream from the shared resource.
REQ-010 SHALL have ports m0_* and m1_* (tdata/tlast/tvalid/tready)  out/out/out/in  WIDTH/1/1/1  per-requester result streams.
REQ-011 SHALL have port inflight  out  TAG_AWIDTH+1  packets granted but whose result tlast has not yet left.
REQ-012 SHALL have port orphan  out  1  one-cycle pulse when a result beat is dropped.
REQ-013 SHALL have ports pkt_cnt0, pkt_cnt1, orphan_cnt  out  32 each  statistics (see Configuration).

Function
REQ-014 SHALL run an arbiter FSM with states IDLE, LOCK0, LOCK1.
REQ-015 In IDLE, SHALL grant on the next edge the requester with tvalid=1, priority to the one indicated by rr pointer; no grant if tag FIFO full or clear=1.
REQ-016 SHALL hold all s*_tready=0 and r_tvalid=0 in IDLE; first beat accepted one cycle after grant at earliest.
REQ-017 In LOCKn, SHALL pass sn combinationally to r (tdata, tlast, tvalid) with sn_tready=r_tready; the other requester's tready=0.
REQ-018 On accepted tlast in LOCKn, SHALL return to IDLE and set the rr pointer to the other requester.
REQ-019 SHALL push requester ID into the tag FIFO on the IDLE->LOCKn transition.
REQ-020 With tag FIFO non-empty, SHALL route rr to m[head]: m[head]_tvalid=rr_tvalid, rr_tready=m[head]_tready, other m_tvalid=0; zero added latency.
REQ-021 SHALL pop the tag FIFO on accepted rr tlast.
REQ-022 With tag FIFO empty, SHALL set rr_tready=1, drop the beat, pulse orphan.
REQ-023 Simultaneous push and pop SHALL leave inflight unchanged; inflight = FIFO occupancy.
REQ-024 clear mid-packet SHALL force IDLE, drop tags; the partial packet tail is not forwarded.

Reset
REQ-025 On reset: state IDLE, rr pointer=requester 0, tag FIFO empty, inflight=0, orphan=0, all counters 0, all tvalid/tready outputs 0 except rr_tready per REQ-022.

Configuration
REQ-026 Macro CORDIC_SHARE_ARB_STATS_EN: when defined, pkt_cnt0/pkt_cnt1 SHALL increment per accepted input tlast of that requester and orphan_cnt per orphan pulse, wrapping at 2^32; when undefined these outputs SHALL be constant 0 and no counter logic synthesized.

Structure
REQ-027 A shared package cordic_share_arb_pkg SHALL hold the FSM state type, requester ID type and requester count constant.
REQ-028 The tag FIFO SHALL be a sub-module arb_tag_fifo (depth 2^TAG_AWIDTH, 1-bit entries, full/empty, first-word-fall-through).

Verification
REQ-029 Both requesters valid continuously, 4-beat packets -> grants alternate 0,1,0,1; m0/m1 each receive their own data exactly.
REQ-030 Only s1 valid, three packets -> three consecutive LOCK1 grants, one idle cycle between packets, pkt_cnt1=3 with STATS_EN.
REQ-031 Resource stalls rr for 16 packets (TAG_AWIDTH=4) -> inflight reaches 16, no 17th grant until one result tlast pops.
REQ-032 m0_tready=0 while head tag=0 -> rr_tready=0, no beat leaks to m1.
REQ-033 rr beat with inflight=0 -> dropped, orphan pulses 1 cycle, orphan_cnt=1.
REQ-034 clear asserted in LOCK0 mid-packet -> IDLE next cycle, inflight=0; reset asserted mid-packet -> all outputs at REQ-025 values immediately.

Source files
------------

// File: rtl/cordic_share_arb_pkg.sv
// Shared types for the CORDIC sharing arbiter: FSM states, requester IDs and requester count.
package cordic_share_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// First-word-fall-through tag FIFO, depth 2**AW; head visible the cycle after push.
// Push is ignored when full and pop when empty; clear empties it synchronously.
module arb_tag_fifo #(
  parameter int DW = 1,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/cordic_share_arb.sv
// Round-robin packet arbiter sharing one CORDIC/mult pipeline between two streams; zero-latency pass-through both ways.
// Backpressure passes straight through to the locked requester and tag-selected sink; stats counters behind CORDIC_SHARE_ARB_STATS_EN.
module cordic_share_arb
  import cordic_share_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TAG_AWIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [WIDTH-1:0]    s0_tdata,
  input  logic                s0_tlast,
  input  logic                s0_tvalid,
  output logic                s0_tready,
  input  logic [WIDTH-1:0]    s1_tdata,
  input  logic                s1_tlast,
  input  logic                s1_tvalid,
  output logic                s1_tready,
  output logic [WIDTH-1:0]    r_tdata,
  output logic                r_tlast,
  output logic                r_tvalid,
  input  logic                r_tready,
  input  logic [WIDTH-1:0]    rr_tdata,
  input  logic                rr_tlast,
  input  logic                rr_tvalid,
  output logic                rr_tready,
  output logic [WIDTH-1:0]    m0_tdata,
  output logic                m0_tlast,
  output logic                m0_tvalid,
  input  logic                m0_tready,
  output logic [WIDTH-1:0]    m1_tdata,
  output logic                m1_tlast,
  output logic                m1_tvalid,
  input  logic                m1_tready,
  output logic [TAG_AWIDTH:0] inflight,
  output logic                orphan,
  output logic [31:0]         pkt_cnt0,
  output logic [31:0]         pkt_cnt1,
  output logic [31:0]         orphan_cnt
);

  arb_state_t state, state_nxt;
  req_id_t    rr_ptr, rr_ptr_nxt;
  logic       tag_push, tag_pop, tag_full, tag_empty;
  req_id_t    tag_push_dat, tag_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      rr_ptr <= REQ0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    tag_push     = 1'b0;
    tag_push_dat = REQ0;
    s0_tready    = 1'b0;
    s1_tready    = 1'b0;
    r_tdata      = '0;
    r_tlast      = 1'b0;
    r_tvalid     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!clear && !tag_full) begin
          if (s0_tvalid && (!s1_tvalid || rr_ptr == REQ0)) begin
            state_nxt    = ST_LOCK0;
            tag_push     = 1'b1;
            tag_push_dat = REQ0;
          end else if (s1_tvalid) begin
            state_nxt    = ST_LOCK1;
            tag_push     = 1'b1;
            tag_push_dat = REQ1;
          end
        end
      end
      ST_LOCK0: begin
        r_tdata   = s0_tdata;
        r_tlast   = s0_tlast;
        r_tvalid  = s0_tvalid;
        s0_tready = r_tready;
        if (s0_tvalid && r_tready && s0_tlast) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = REQ1;
        end
      end
      ST_LOCK1: begin
        r_tdata   = s1_tdata;
        r_tlast   = s1_tlast;
        r_tvalid  = s1_tvalid;
        s1_tready = r_tready;
        if (s1_tvalid && r_tready && s1_tlast) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = REQ0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear) state_nxt = ST_IDLE;
  end

  arb_tag_fifo #(
    .DW (1),
    .AW (TAG_AWIDTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push     (tag_push),
    .push_dat (tag_push_dat),
    .pop      (tag_pop),
    .pop_dat  (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (inflight)
  );

  // Results come back in grant order, so the FIFO head names the owner of the current rr beat.
  always_comb begin
    m0_tvalid = 1'b0;
    m1_tvalid = 1'b0;
    rr_tready = 1'b1;
    if (!tag_empty) begin
      if (tag_head == REQ0) begin
        m0_tvalid = rr_tvalid;
        rr_tready = m0_tready;
      end else begin
        m1_tvalid = rr_tvalid;
        rr_tready = m1_tready;
      end
    end
  end

  assign m0_tdata = rr_tdata;
  assign m0_tlast = rr_tlast;
  assign m1_tdata = rr_tdata;
  assign m1_tlast = rr_tlast;
  assign tag_pop  = rr_tvalid && rr_tready && rr_tlast && !tag_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) orphan <= 1'b0;
    else       orphan <= rr_tvalid && tag_empty;
  end

`ifdef CORDIC_SHARE_ARB_STATS_EN
  logic s0_last_hs, s1_last_hs;
  assign s0_last_hs = s0_tvalid && s0_tready && s0_tlast;
  assign s1_last_hs = s1_tvalid && s1_tready && s1_tlast;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt0   <= '0;
      pkt_cnt1   <= '0;
      orphan_cnt <= '0;
    end else begin
      if (s0_last_hs) pkt_cnt0   <= pkt_cnt0 + 32'd1;
      if (s1_last_hs) pkt_cnt1   <= pkt_cnt1 + 32'd1;
      if (orphan)     orphan_cnt <= orphan_cnt + 32'd1;
    end
  end
`else
  assign pkt_cnt0   = '0;
  assign pkt_cnt1   = '0;
  assign orphan_cnt = '0;
`endif

endmodule

// File: tb/tb_cordic_share_arb.sv
// Randomized bench for cordic_share_arb against a queue-based transaction model of the arbitration and result routing.
module tb_cordic_share_arb;

`ifdef CORDIC_SHARE_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk, reset, clear;
  logic [31:0] s_td [2];
  logic [1:0]  s_tl, s_tv;
  logic        s0_tready, s1_tready;
  logic [31:0] r_tdata;
  logic        r_tlast, r_tvalid, r_tready;
  logic [31:0] rr_tdata;
  logic        rr_tlast, rr_tvalid, rr_tready;
  logic [31:0] m0_tdata, m1_tdata;
  logic        m0_tlast, m0_tvalid, m0_tready;
  logic        m1_tlast, m1_tvalid, m1_tready;
  logic [4:0]  inflight;
  logic        orphan;
  logic [31:0] pkt_cnt0, pkt_cnt1, orphan_cnt;

  cordic_share_arb dut (
    .clk(clk), .reset(reset), .clear(clear),
    .s0_tdata(s_td[0]), .s0_tlast(s_tl[0]), .s0_tvalid(s_tv[0]), .s0_tready(s0_tready),
    .s1_tdata(s_td[1]), .s1_tlast(s_tl[1]), .s1_tvalid(s_tv[1]), .s1_tready(s1_tready),
    .r_tdata(r_tdata), .r_tlast(r_tlast), .r_tvalid(r_tvalid), .r_tready(r_tready),
    .rr_tdata(rr_tdata), .rr_tlast(rr_tlast), .rr_tvalid(rr_tvalid), .rr_tready(rr_tready),
    .m0_tdata(m0_tdata), .m0_tlast(m0_tlast), .m0_tvalid(m0_tvalid), .m0_tready(m0_tready),
    .m1_tdata(m1_tdata), .m1_tlast(m1_tlast), .m1_tvalid(m1_tvalid), .m1_tready(m1_tready),
    .inflight(inflight), .orphan(orphan),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .orphan_cnt(orphan_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus knobs (percent, clear per mille)
  int p_s0, p_s1, p_r, p_rr, p_m0, p_m1, p_clr, fixed_len;
  bit orph_inj, force_clr;

  // Reference model state
  int owner, rrp, cnt0, cnt1, ocnt;
  int tags [$];
  int grants [$];
  logic orph_exp;
  logic [32:0] res_q [$];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int beat [2], pkt [2], plen [2];
  bit rr_from_res;
  int max_infl, orph_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int newlen();
    return (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 4));
  endfunction

  function automatic logic [31:0] stat_exp(input int c);
    return STATS_EN ? 32'(c) : 32'd0;
  endfunction

  task automatic model_reset();
    owner = -1; rrp = 0; cnt0 = 0; cnt1 = 0; ocnt = 0; orph_exp = 1'b0;
    tags.delete(); res_q.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_s0_tready"}, 32'(s0_tready), 32'd0);
    chk({pfx, "_s1_tready"}, 32'(s1_tready), 32'd0);
    chk({pfx, "_r_tvalid"},  32'(r_tvalid), 32'd0);
    chk({pfx, "_m0_tvalid"}, 32'(m0_tvalid), 32'd0);
    chk({pfx, "_m1_tvalid"}, 32'(m1_tvalid), 32'd0);
    chk({pfx, "_rr_tready"}, 32'(rr_tready), 32'd1);
    chk({pfx, "_inflight"},  32'(inflight), 32'd0);
    chk({pfx, "_orphan"},    32'(orphan), 32'd0);
    chk({pfx, "_pkt_cnt0"},  pkt_cnt0, 32'd0);
    chk({pfx, "_pkt_cnt1"},  pkt_cnt1, 32'd0);
    chk({pfx, "_orphan_cnt"}, orphan_cnt, 32'd0);
  endtask

  task automatic step();
    logic [1:0] e_s_rdy, e_m_v;
    logic e_r_v, e_rr_rdy, r_hs, rr_hs, last, nxt_orph, clr;
    logic [31:0] m_obs;
    int o, occ, h, g;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      s_tv[i] = (($urandom % 100) < ((i == 0) ? p_s0 : p_s1));
      s_td[i] = (32'(i) << 31) | ((32'(pkt[i]) & 32'h7fff) << 16) | (32'(beat[i]) & 32'hffff);
      s_tl[i] = (beat[i] == plen[i] - 1);
    end
    r_tready  = (($urandom % 100) < p_r);
    m0_tready = (($urandom % 100) < p_m0);
    m1_tready = (($urandom % 100) < p_m1);
    rr_from_res = 1'b0; rr_tvalid = 1'b0; rr_tlast = 1'b0; rr_tdata = 32'd0;
    if (res_q.size() > 0) begin
      if (($urandom % 100) < p_rr) begin
        rr_tvalid = 1'b1; {rr_tlast, rr_tdata} = res_q[0]; rr_from_res = 1'b1;
      end
    end else if (orph_inj && tags.size() == 0 && ($urandom % 100) < 30) begin
      rr_tvalid = 1'b1; rr_tdata = $urandom; rr_tlast = 1'($urandom % 2);
    end
    clr = force_clr || (($urandom % 1000) < p_clr);
    clear = clr;
    #1;
    // Expected combinational view from the model
    e_s_rdy = 2'b00; e_r_v = 1'b0; e_m_v = 2'b00; e_rr_rdy = 1'b1; h = 0;
    if (owner >= 0) begin
      e_r_v = s_tv[owner];
      e_s_rdy[owner] = r_tready;
    end
    occ = tags.size();
    if (occ > 0) begin
      h = tags[0];
      e_m_v[h] = rr_tvalid;
      e_rr_rdy = (h == 0) ? m0_tready : m1_tready;
    end
    chk("s0_tready", 32'(s0_tready), 32'(e_s_rdy[0]));
    chk("s1_tready", 32'(s1_tready), 32'(e_s_rdy[1]));
    chk("r_tvalid", 32'(r_tvalid), 32'(e_r_v));
    if (e_r_v) begin
      chk("r_tdata", r_tdata, s_td[owner]);
      chk("r_tlast", 32'(r_tlast), 32'(s_tl[owner]));
    end
    chk("rr_tready", 32'(rr_tready), 32'(e_rr_rdy));
    chk("m0_tvalid", 32'(m0_tvalid), 32'(e_m_v[0]));
    chk("m1_tvalid", 32'(m1_tvalid), 32'(e_m_v[1]));
    m_obs = (h == 1) ? m1_tdata : m0_tdata;
    if (e_m_v[0]) chk("m0_tlast", 32'(m0_tlast), 32'(rr_tlast));
    if (e_m_v[1]) chk("m1_tlast", 32'(m1_tlast), 32'(rr_tlast));
    chk("inflight", 32'(inflight), 32'(occ));
    chk("orphan", 32'(orphan), 32'(orph_exp));
    chk("pkt_cnt0", pkt_cnt0, stat_exp(cnt0));
    chk("pkt_cnt1", pkt_cnt1, stat_exp(cnt1));
    chk("orphan_cnt", orphan_cnt, stat_exp(ocnt));
    if (32'(inflight) > 32'(max_infl)) max_infl = int'(inflight);
    if (orphan === 1'b1) orph_seen++;
    @(posedge clk);
    // Advance the model using the values that were stable at this edge
    o = owner;
    r_hs = e_r_v && r_tready;
    last = (o >= 0) ? s_tl[o] : 1'b0;
    if (r_hs) begin
      if (!clr) begin
        if (o == 0) exp_q0.push_back(s_td[o]); else exp_q1.push_back(s_td[o]);
        res_q.push_back({last, s_td[o]});
      end
      beat[o]++;
      if (last) begin
        beat[o] = 0; pkt[o]++; plen[o] = newlen();
        if (o == 0) cnt0++; else cnt1++;
      end
    end
    rr_hs = rr_tvalid && e_rr_rdy;
    nxt_orph = rr_tvalid && (occ == 0);
    if (rr_hs && occ > 0) begin
      if (h == 0) begin
        chk("m0_depth", 32'(exp_q0.size() > 0), 32'd1);
        if (exp_q0.size() > 0) chk("m0_e2e", m_obs, exp_q0.pop_front());
      end else begin
        chk("m1_depth", 32'(exp_q1.size() > 0), 32'd1);
        if (exp_q1.size() > 0) chk("m1_e2e", m_obs, exp_q1.pop_front());
      end
      if (rr_from_res) void'(res_q.pop_front());
      if (rr_tlast) void'(tags.pop_front());
    end
    if (orph_exp) ocnt++;
    orph_exp = nxt_orph;
    if (r_hs && last) rrp = 1 - o;
    if (clr) begin
      owner = -1;
      tags.delete(); res_q.delete(); exp_q0.delete(); exp_q1.delete();
    end else if (o < 0) begin
      if (occ < 16) begin
        g = -1;
        if (s_tv[rrp]) g = rrp;
        else if (s_tv[1 - rrp]) g = 1 - rrp;
        if (g >= 0) begin
          owner = g; tags.push_back(g); grants.push_back(g);
        end
      end
    end else if (r_hs && last) begin
      owner = -1;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int c1;
    bit found;
    reset = 1'b1; clear = 1'b0; s_tv = 2'b00; s_tl = 2'b00; s_td[0] = 32'd0; s_td[1] = 32'd0;
    r_tready = 1'b0; rr_tvalid = 1'b0; rr_tdata = 32'd0; rr_tlast = 1'b0;
    m0_tready = 1'b0; m1_tready = 1'b0;
    p_s0 = 100; p_s1 = 100; p_r = 100; p_rr = 100; p_m0 = 100; p_m1 = 100;
    p_clr = 0; fixed_len = 4; orph_inj = 1'b0; force_clr = 1'b0;
    max_infl = 0; orph_seen = 0;
    for (int i = 0; i < 2; i++) begin beat[i] = 0; pkt[i] = 0; plen[i] = 4; end
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_reset("rst");
    @(negedge clk);
    reset = 1'b0;

    // Both requesters saturated, 4-beat packets: grants must alternate
    grants.delete();
    run(80);
    chk("alt_count", 32'(grants.size() >= 8), 32'd1);
    for (int i = 0; i < grants.size(); i++) chk("alt_grant", 32'(grants[i]), 32'(i % 2));

    // Only s1 active: three back-to-back LOCK1 packets
    force_clr = 1'b1; run(1); force_clr = 1'b0;
    p_s0 = 0; grants.delete(); c1 = cnt1;
    for (int k = 0; k < 100 && cnt1 < c1 + 3; k++) step();
    p_s1 = 0;
    run(4);
    chk("s1_pkts", 32'(cnt1 - c1), 32'd3);
    chk("s1_grants", 32'(grants.size()), 32'd3);
    foreach (grants[i]) chk("s1_grant_id", 32'(grants[i]), 32'd1);

    // Resource stalled: tag FIFO fills to 16 and blocks further grants
    p_s0 = 100; p_s1 = 100; p_rr = 0; fixed_len = 0; max_infl = 0;
    run(200);
    chk("inflight_max", 32'(max_infl), 32'd16);
    p_rr = 100;
    run(150);

    // m0 stalled: head-of-line results for requester 0 must not leak to m1
    p_m0 = 0;
    run(60);
    p_m0 = 100;
    run(60);

    // Orphan results with an empty tag FIFO
    force_clr = 1'b1; run(1); force_clr = 1'b0;
    p_s0 = 0; p_s1 = 0; orph_inj = 1'b1; orph_seen = 0;
    run(40);
    chk("orphan_seen", 32'(orph_seen > 0), 32'd1);

    // Fully random traffic with occasional clears
    p_s0 = 60; p_s1 = 60; p_r = 70; p_rr = 60; p_m0 = 70; p_m1 = 70; p_clr = 5;
    run(3000);

    // Asynchronous reset in the middle of a packet
    p_s0 = 100; p_s1 = 100; p_r = 100; p_clr = 0; orph_inj = 1'b0; fixed_len = 4;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      if (owner >= 0 && beat[owner] > 0) found = 1'b1;
    end
    chk("rst_mid_found", 32'(found), 32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset("rst_mid");
    s_tv = 2'b00; rr_tvalid = 1'b0; clear = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    p_s0 = 60; p_s1 = 60; p_r = 70; p_rr = 60; p_m0 = 70; p_m1 = 70; fixed_len = 0;
    run(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
